// File: rtl/voter_id_registry.sv
// voter_id_registry: records voter IDs that have voted and flags repeat voters
module voter_id_registry #(
    parameter int ID_WIDTH   = 5,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  mode,
    input  logic                  control,
    input  logic                  req_valid,
    input  logic [1:0]            req_op,
    input  logic [ID_WIDTH-1:0]   req_id,
    output logic                  req_ready,
    output logic                  rsp_valid,
    output logic                  rsp_found,
    output logic                  rsp_inserted,
    output logic                  rsp_full,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  full
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] ONE = (ADDR_WIDTH + 1)'(1);
    localparam logic [1:0] OP_REG = 2'd1;
    localparam logic [1:0] OP_CLR = 2'd2;

    typedef enum logic [2:0] {IDLE, SCAN, INSERT, CLEAR_ST, RESP} state_t;

    state_t                 state, state_n;
    logic [1:0]             op_q;
    logic [ID_WIDTH-1:0]    id_q;
    logic [ADDR_WIDTH-1:0]  idx;
    logic [ID_WIDTH-1:0]    mem [DEPTH];
    logic [DEPTH-1:0]       valid;
    logic                   accept, hit, last, is_reg;
    logic                   nf, ni, nfull;

    assign req_ready = (state == IDLE) && mode && control;
    assign accept    = req_valid && req_ready;
    assign rsp_valid = (state == RESP);
    assign full      = (count == DEPTH_C);
    assign is_reg    = (op_q == OP_REG);
    // valid bit guards against an empty slot matching ID 0
    assign hit       = valid[idx] && (mem[idx] == id_q);
    assign last      = (({1'b0, idx} + ONE) == count);

    // next state and the response flags captured on entry to RESP
    always_comb begin
        state_n = state;
        nf      = (state == SCAN) && hit;
        ni      = (state == INSERT);
        nfull   = (state == SCAN) && !hit && last && is_reg && full;
        case (state)
            IDLE:     state_n = !accept ? IDLE :
                                (req_op == OP_CLR) ? CLEAR_ST :
                                (count != '0) ? SCAN :
                                (req_op == OP_REG) ? INSERT : RESP;
            SCAN:     state_n = hit ? RESP : !last ? SCAN :
                                (is_reg && !full) ? INSERT : RESP;
            INSERT:   state_n = RESP;
            CLEAR_ST: state_n = RESP;
            default:  state_n = IDLE;
        endcase
    end

    // control state, occupancy and response flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            op_q         <= '0;
            id_q         <= '0;
            idx          <= '0;
            count        <= '0;
            valid        <= '0;
            rsp_found    <= 1'b0;
            rsp_inserted <= 1'b0;
            rsp_full     <= 1'b0;
        end else begin
            state <= state_n;
            if (accept) begin
                op_q <= req_op;
                id_q <= req_id;
                idx  <= '0;
            end
            if (state == SCAN && state_n == SCAN)
                idx <= idx + ADDR_WIDTH'(1);
            if (state == INSERT) begin
                valid[count[ADDR_WIDTH-1:0]] <= 1'b1;
                count                        <= count + ONE;
            end
            if (state == CLEAR_ST) begin
                valid <= '0;
                count <= '0;
            end
            if (state_n == RESP) begin
                rsp_found    <= nf;
                rsp_inserted <= ni;
                rsp_full     <= nfull;
            end
        end
    end

    // ID storage; contents beyond count are don't-care so no reset is needed
    always_ff @(posedge clk) begin
        if (state == INSERT)
            mem[count[ADDR_WIDTH-1:0]] <= id_q;
    end
endmodule

// File: tb/tb_voter_id_registry.sv
// tb_voter_id_registry: directed and random checks of the registry against a queue model
module tb_voter_id_registry;
    logic        clk = 0, reset = 1, mode = 1, control = 1, req_valid = 0;
    logic [1:0]  req_op = 0;
    logic [4:0]  req_id = 0;
    logic        req_ready, rsp_valid, rsp_found, rsp_inserted, rsp_full, full;
    logic [4:0]  count;
    int          checks = 0, failures = 0;
    int          model[$];

    always #5 clk = ~clk;

    voter_id_registry #(.ID_WIDTH(5), .ADDR_WIDTH(4)) dut (
        .clk(clk), .reset(reset), .mode(mode), .control(control),
        .req_valid(req_valid), .req_op(req_op), .req_id(req_id),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_found(rsp_found),
        .rsp_inserted(rsp_inserted), .rsp_full(rsp_full),
        .count(count), .full(full)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic do_req(input logic [1:0] op, input logic [4:0] id, input bit drop);
        int k, pos, exp_lat, lat;
        bit ef, ei, efu;
        k = model.size();
        pos = -1;
        ef = 0; ei = 0; efu = 0;
        foreach (model[i]) if (pos < 0 && model[i] == int'(id)) pos = i;
        if (op == 2) begin exp_lat = 2; model.delete(); end
        else if (pos >= 0) begin exp_lat = pos + 2; ef = 1; end
        else if (op == 1 && k < 16) begin exp_lat = k + 2; ei = 1; model.push_back(int'(id)); end
        else if (op == 1) begin exp_lat = k + 1; efu = 1; end
        else exp_lat = k + 1;
        @(negedge clk);
        req_valid = 1; req_op = op; req_id = id;
        chk("req_ready_idle", req_ready, 1);
        @(posedge clk);
        #1 req_valid = 0; req_id = ~id;
        lat = 0;
        while (lat < 40) begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                chk("req_ready_busy", req_ready, 0);
                if (drop) mode = 0;
            end
            if (rsp_valid) break;
        end
        chk("latency", lat, exp_lat);
        chk("rsp_found", rsp_found, ef);
        chk("rsp_inserted", rsp_inserted, ei);
        chk("rsp_full", rsp_full, efu);
        chk("count", count, model.size());
        chk("full", full, model.size() == 16);
        @(negedge clk);
        chk("rsp_pulse", rsp_valid, 0);
        chk("found_hold", rsp_found, ef);
        chk("inserted_hold", rsp_inserted, ei);
        mode = 1;
    endtask

    initial begin
        int r;
        repeat (2) @(negedge clk);
        chk("reset_count", count, 0);
        chk("reset_full", full, 0);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_flags", {rsp_found, rsp_inserted, rsp_full}, 0);
        reset = 0;
        @(negedge clk);
        chk("ready_after_reset", req_ready, 1);

        do_req(0, 0, 0);
        do_req(1, 3, 0);
        do_req(1, 7, 0);
        do_req(1, 9, 0);
        do_req(1, 7, 0);

        do_req(2, 0, 0);
        for (int i = 0; i < 16; i++) do_req(1, 5'(i), 0);
        do_req(1, 20, 0);
        do_req(0, 0, 0);
        do_req(0, 15, 0);
        do_req(1, 3, 0);
        do_req(2, 0, 0);

        for (int i = 10; i < 14; i++) do_req(1, 5'(i), 0);
        do_req(1, 5, 1);

        @(negedge clk);
        mode = 0; req_valid = 1; req_op = 1; req_id = 22;
        repeat (4) begin
            @(negedge clk);
            chk("gated_mode_ready", req_ready, 0);
            chk("gated_mode_rsp", rsp_valid, 0);
        end
        mode = 1; control = 0;
        repeat (3) begin
            @(negedge clk);
            chk("gated_ctrl_ready", req_ready, 0);
            chk("gated_ctrl_rsp", rsp_valid, 0);
        end
        req_valid = 0; control = 1;
        chk("gated_count", count, model.size());

        for (int n = 0; n < 60; n++) begin
            r = $urandom_range(0, 19);
            do_req(r < 10 ? 2'd1 : r < 16 ? 2'd0 : r < 19 ? 2'd3 : 2'd2,
                   5'($urandom_range(0, 31)), 0);
        end

        do_req(2, 0, 0);
        for (int i = 16; i < 24; i++) do_req(1, 5'(i), 0);
        @(negedge clk);
        req_valid = 1; req_op = 0; req_id = 31;
        @(posedge clk);
        #1 req_valid = 0;
        repeat (3) @(negedge clk);
        reset = 1;
        model.delete();
        #1;
        chk("abort_count", count, 0);
        chk("abort_full", full, 0);
        repeat (12) begin
            @(negedge clk);
            reset = 0;
            chk("abort_no_rsp", rsp_valid, 0);
        end
        chk("abort_count_after", count, 0);
        do_req(0, 18, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
